// File: rtl/add64_sched.sv
// Two-requester round-robin front end for one shared, clocked 32-bit adder.
// Each 64-bit add runs as a low-word pass and then a high-word pass with the low carry chained in.
module add64_sched #(
    parameter int LAT = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_ci,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_ci,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic [31:0] add_s,
    input  logic        add_co,
    output logic [63:0] sum,
    output logic        co,
    output logic        done,
    output logic        done_id,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t      st;
    logic [3:0]  cnt;
    logic        ptr;
    logic        id;
    logic [31:0] a_hi;
    logic [31:0] b_hi;
    logic [31:0] sum_lo;

    logic        win;
    logic [63:0] sel_a;
    logic [63:0] sel_b;
    logic        sel_ci;

    assign state = st;

    // ptr holds the last granted requester, so a tie goes to the other one.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10 || (req == 2'b11 && !ptr)) begin
            win = 1'b1;
        end
        sel_a  = win ? req1_a  : req0_a;
        sel_b  = win ? req1_b  : req0_b;
        sel_ci = win ? req1_ci : req0_ci;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st      <= IDLE;
            cnt     <= 4'd0;
            ptr     <= 1'b1;
            id      <= 1'b0;
            a_hi    <= 32'd0;
            b_hi    <= 32'd0;
            sum_lo  <= 32'd0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            add_a   <= 32'd0;
            add_b   <= 32'd0;
            add_ci  <= 1'b0;
            sum     <= 64'd0;
            co      <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (|req) begin
                        st     <= LO;
                        busy   <= 1'b1;
                        cnt    <= 4'd0;
                        gnt    <= win ? 2'b10 : 2'b01;
                        ptr    <= win;
                        id     <= win;
                        a_hi   <= sel_a[63:32];
                        b_hi   <= sel_b[63:32];
                        add_a  <= sel_a[31:0];
                        add_b  <= sel_b[31:0];
                        add_ci <= sel_ci;
                    end
                end
                LO: begin
                    if (cnt == LAT_C) begin
                        // add_ci doubles as the low-pass carry register for the high pass.
                        st     <= HI;
                        cnt    <= 4'd0;
                        sum_lo <= add_s;
                        add_a  <= a_hi;
                        add_b  <= b_hi;
                        add_ci <= add_co;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (cnt == LAT_C) begin
                        st      <= DONE;
                        cnt     <= 4'd0;
                        sum     <= {add_s, sum_lo};
                        co      <= add_co;
                        done_id <= id;
                        done    <= 1'b1;
                        add_a   <= 32'd0;
                        add_b   <= 32'd0;
                        add_ci  <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule
